// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer that drives the next-PC value of an external ProgramCounter.
// It handles fetch handshakes with a timeout, decode stalls, jump/branch redirects and traps.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] PCNext,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  output logic        trap_active,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_TRAP  = 3'd4
  } state_t;

  localparam logic [7:0] MAX_WAIT_C   = 8'(MAX_WAIT);
  localparam logic [1:0] CAUSE_EXT    = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN  = 2'b10;
  localparam logic [1:0] CAUSE_TMOUT  = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic [31:0] pc_next_s;
  logic        imem_req_s;
  logic        instr_valid_s;
  logic        trap_active_s;
  logic        redir_sel_s;
  logic [31:0] redir_tgt_s;
  logic        redir_misaligned_s;

  // Jump outranks branch when both are asserted.
  assign redir_sel_s        = jump | branch_taken;
  assign redir_tgt_s        = jump ? jump_target : branch_target;
  assign redir_misaligned_s = |redir_tgt_s[1:0];

  // Next-state, trap capture and output decode.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    trap_cause_d  = trap_cause_q;
    trap_pc_d     = trap_pc_q;
    pc_next_s     = PC;
    imem_req_s    = 1'b0;
    instr_valid_s = 1'b0;
    trap_active_s = 1'b0;
    if (reset) begin
      state_d      = ST_BOOT;
      wait_cnt_d   = 8'd0;
      trap_cause_d = 2'b00;
      trap_pc_d    = 32'h0000_0000;
      pc_next_s    = RESET_VECTOR;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_next_s = RESET_VECTOR;
          state_d   = ST_FETCH;
        end
        ST_FETCH: begin
          imem_req_s = 1'b1;
          if (imem_ack) begin
            state_d = ST_ISSUE;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 8'd1;
          end
        end
        ST_WAIT: begin
          imem_req_s = 1'b1;
          if (imem_ack) begin
            state_d = ST_ISSUE;
          end else if (wait_cnt_q == MAX_WAIT_C) begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_TMOUT;
            trap_pc_d    = PC;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        ST_ISSUE: begin
          instr_valid_s = 1'b1;
          if (stall) begin
            state_d = ST_ISSUE;
          end else if (trap_req) begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_EXT;
            trap_pc_d    = PC;
          end else if (redir_sel_s) begin
            if (redir_misaligned_s) begin
              state_d      = ST_TRAP;
              trap_cause_d = CAUSE_ALIGN;
              trap_pc_d    = PC;
            end else begin
              pc_next_s = redir_tgt_s;
              state_d   = ST_FETCH;
            end
          end else begin
            pc_next_s = PC + 32'd4;
            state_d   = ST_FETCH;
          end
        end
        ST_TRAP: begin
          pc_next_s     = TRAP_VECTOR;
          trap_active_s = 1'b1;
          state_d       = ST_FETCH;
        end
        default: begin
          pc_next_s = RESET_VECTOR;
          state_d   = ST_BOOT;
        end
      endcase
    end
  end

  // State, wait counter and trap record registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      wait_cnt_q   <= 8'd0;
      trap_cause_q <= 2'b00;
      trap_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  assign PCNext      = pc_next_s;
  assign imem_req    = imem_req_s;
  assign instr_valid = instr_valid_s;
  assign trap_active = trap_active_s;
  assign trap_cause  = trap_cause_q;
  assign trap_pc     = trap_pc_q;

endmodule
